logic_op_scheduler: RTL
=======================

# logic_op_scheduler

Sequencer that shares one WIDTH-bit logic lane across SETS packed operand sets, so the mXnBits operation set (NOT, AND, OR, NAND, NOR, XOR, XNOR) runs without SETS parallel gate copies. Accepts one command with an opcode and two packed operands through a valid/ready handshake, processes one set per clock, and presents the assembled packed result with a result handshake. Sits between the ALU decode stage and result writeback, as the area-reduced alternative to the fully parallel mXnBits gates.

## Interface
Parameters:
- WIDTH, 4, bits per operand set
- SETS, 2, number of sets per packed operand (≥1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  scheduler can accept a command
- in_op  in  3  opcode: 0 NOT, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal
- in1_packed  in  SETS*WIDTH  operand A; set i at [i*WIDTH +: WIDTH]
- in2_packed  in  SETS*WIDTH  operand B (ignored for NOT)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_packed  out  SETS*WIDTH  result; same set layout as inputs
- out_err  out  1  command carried illegal opcode; valid with out_valid
- busy  out  1  high in RUN and DONE
- out_parity  out  SETS  per-set even parity of result (only with LOGIC_SCHED_PARITY_EN)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: latch in_op, in1_packed, in2_packed; clear out_packed, out_err; idx←0; → RUN.
- RUN: in_ready=0. Each cycle the lane computes op(A[idx], B[idx]) and writes it to out_packed[idx*WIDTH +: WIDTH]; idx←idx+1. After writing set SETS-1 → DONE.
- Illegal opcode (7): still passes through RUN for SETS cycles; lane output forced to 0; out_err←1 at acceptance.
- DONE: out_valid=1, out_packed/out_err/out_parity stable. On out_ready → IDLE. out_ready outside DONE ignored.
- Latched command immune to input changes after acceptance.
- idx width $clog2(SETS) (min 1); never exceeds SETS-1; no wrap in RUN.
- Reset mid-RUN or mid-DONE: immediate return to IDLE, all outputs to reset values, partial result discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_packed=0, out_err=0, busy=0, out_parity=0.
- Acceptance edge E0 (in_valid & in_ready sampled high). Set k written at edge E(k+1); out_valid high after edge E(SETS): latency SETS cycles.
- Result held indefinitely while out_ready=0.
- DONE exit at edge where out_ready=1; in_ready high in following cycle; no same-cycle accept/release. Peak throughput: one command per SETS+2 cycles.
- in_ready and out_valid are state-decoded registers only; no combinational input-to-output paths.

## Configuration
- LOGIC_SCHED_PARITY_EN defined: out_parity port exists; bit i = ^out_packed set i, updated with each lane write, 0 at reset/acceptance.
- Undefined: out_parity port and logic absent; all other behaviour identical.

## Structure
- Package logic_sched_pkg: opcode localparams (OP_NOT..OP_XNOR, OP_ILLEGAL), state encoding (ST_IDLE, ST_RUN, ST_DONE), opcode width 3.
- One sub-module: logic_lane — combinational WIDTH-bit op unit (op, a, b → y, illegal → 0); scheduler owns all registers.

## Test plan
- Reset then idle: rst pulse → in_ready=1, out_valid=0, out_packed=0x00, busy=0.
- AND, WIDTH=4, SETS=2: in1=0xC5, in2=0xA3, op=1 → out_valid exactly 2 cycles after accept, out_packed=0x81, out_err=0; held across 3 cycles of out_ready=0, released on out_ready=1.
- NOT ignores B: in1=0x3F, in2=0xFF, op=0 → out_packed=0xC0; with parity macro out_parity=2'b00.
- XNOR then back-to-back: op=6, 0x96/0x5A → 0x33; second in_valid held high during RUN/DONE accepted only after release; XOR 0x0F/0xFF → 0xF0.
- Illegal opcode: op=7, 0xFF/0xFF → out_packed=0x00, out_err=1 after 2 cycles.
- Reset mid-RUN: rst after first set written → all outputs at reset values, next command OR 0x10/0x01 → 0x11.

Source files
------------

// File: rtl/logic_sched_pkg.sv
// Shared opcode encodings and scheduler state type for logic_op_scheduler.
package logic_sched_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT     = 3'd0;
  localparam logic [OP_W-1:0] OP_AND     = 3'd1;
  localparam logic [OP_W-1:0] OP_OR      = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/logic_lane.sv
// Combinational WIDTH-bit logic unit shared by every operand set; illegal opcodes yield zero.
module logic_lane
  import logic_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_scheduler.sv
// Time-multiplexes one logic lane over SETS packed operand sets, one set per clock.
// Optional per-set result parity output enabled by defining LOGIC_SCHED_PARITY_EN.
module logic_op_scheduler
  import logic_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic [SETS*WIDTH-1:0] in1_packed,
  input  logic [SETS*WIDTH-1:0] in2_packed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SETS*WIDTH-1:0] out_packed,
  output logic                  out_err,
  output logic                  busy
`ifdef LOGIC_SCHED_PARITY_EN
  ,
  output logic [SETS-1:0]       out_parity
`endif
);

  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  state_t state, next_state;

  logic [OP_W-1:0]       op_q;
  logic [SETS*WIDTH-1:0] a_q;
  logic [SETS*WIDTH-1:0] b_q;
  logic [IDX_W-1:0]      idx;
  logic [WIDTH-1:0]      lane_a;
  logic [WIDTH-1:0]      lane_b;
  logic [WIDTH-1:0]      lane_y;

  logic accept;
  logic last_set;

  assign accept   = (state == ST_IDLE) && in_valid;
  assign last_set = (idx == LAST_IDX);

  // Handshake outputs decode the state register only, so no input reaches them combinationally.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (in_valid)  next_state = ST_RUN;
      ST_RUN:  if (last_set)  next_state = ST_DONE;
      ST_DONE: if (out_ready) next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  assign lane_a = a_q[idx*WIDTH +: WIDTH];
  assign lane_b = b_q[idx*WIDTH +: WIDTH];

  logic_lane #(.WIDTH(WIDTH)) u_lane (
    .op (op_q),
    .a  (lane_a),
    .b  (lane_b),
    .y  (lane_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_NOT;
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      out_packed <= '0;
      out_err    <= 1'b0;
    end else if (accept) begin
      op_q       <= in_op;
      a_q        <= in1_packed;
      b_q        <= in2_packed;
      idx        <= '0;
      out_packed <= '0;
      out_err    <= is_illegal(in_op);
    end else if (state == ST_RUN) begin
      out_packed[idx*WIDTH +: WIDTH] <= lane_y;
      // idx parks on the last set rather than wrapping.
      if (!last_set) idx <= idx + 1'b1;
    end
  end

`ifdef LOGIC_SCHED_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity <= '0;
    end else if (accept) begin
      out_parity <= '0;
    end else if (state == ST_RUN) begin
      out_parity[idx] <= ^lane_y;
    end
  end
`endif

endmodule
